// File: rtl/id_ex_pipe_pkg.sv
// id_ex_pipe_pkg: shared definitions for the ID/EX pipeline register.
//   - control-word field widths
//   - packed control-word type, shared with the decoder and the EX/MEM register
//   - the bubble control word (every control bit zero)
//   - ALU operation codes used by the decoder
package id_ex_pipe_pkg;

  localparam int REGDST_W    = 2;
  localparam int DATATOREG_W = 2;
  localparam int PCSEL_W     = 2;
  localparam int ALUCTRL_W   = 5;

  typedef struct packed {
    logic [REGDST_W-1:0]    reg_dst;
    logic [DATATOREG_W-1:0] datato_reg;
    logic [PCSEL_W-1:0]     pc_sel;
    logic                   alu_src_a;
    logic                   alu_src_b;
    logic                   mem_read;
    logic                   reg_write;
    logic                   mem_write;
    logic                   jump;
    logic [ALUCTRL_W-1:0]   alu_ctrl;
  } ctrl_t;

  // A bubble carries no side effects: no write, no memory access, no jump.
  localparam ctrl_t CTRL_BUBBLE = '0;

  localparam logic [ALUCTRL_W-1:0] ALU_AND = 5'b00000;
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = 5'b00001;
  localparam logic [ALUCTRL_W-1:0] ALU_ADD = 5'b00010;
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = 5'b00110;

endpackage

// File: rtl/load_use_det.sv
// load_use_det: combinational load-use hazard detector.
// Flags an instruction in ID that reads the register a load in EX is about
// to write. The rt comparison is deliberately conservative and is applied
// whatever the ID instruction type. Writes to $0 never create a hazard.
// Ports:
//   ex_valid, ex_mem_read, ex_rt : instruction currently in EX
//   id_valid, id_rs, id_rt       : instruction currently in ID
//   flush                        : ID instruction is being discarded
//   hazard                       : load-use hazard present this cycle
module load_use_det #(
  parameter int RW = 5
) (
  input  logic          ex_valid,
  input  logic          ex_mem_read,
  input  logic [RW-1:0] ex_rt,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          flush,
  output logic          hazard
);

  logic rt_nonzero;
  logic src_match;

  assign rt_nonzero = |ex_rt;
  assign src_match  = (ex_rt == id_rs) || (ex_rt == id_rt);
  assign hazard     = ex_valid && ex_mem_read && rt_nonzero &&
                      id_valid && src_match && !flush;

endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register of the five-stage MIPS pipeline.
// Captures the decoded control word, operands, immediate and register
// specifiers and presents them to EX one cycle later. Inserts bubbles on
// flush, load-use hazard and invalid ID slot; freezes on hold.
//
// Next-state priority: reset > flush > hold > load-use stall > !id_valid > load.
//
// Handshake: there is no valid/ready pair here. id_valid qualifies the ID
// slot; hold freezes this register (upstream must also stall on hold);
// stall_req asks PC and IF/ID to hold for the current cycle and is never
// asserted while hold or flush is high.
//
// Build option: LOAD_USE_DETECT_EN compiles in the load-use comparator.
// Without it stall_req is tied low and hazards are handled externally
// through hold/flush.
//
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   id_*             : decoded fields from ID (control, data, specifiers)
//   flush, hold      : bubble request / freeze request
//   ex_*             : registered copies of every id_* field, plus ex_valid
//   stall_req        : load-use stall request to PC and IF/ID
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [REGDST_W-1:0]    id_RegDst,
  input  logic [DATATOREG_W-1:0] id_DatatoReg,
  input  logic [PCSEL_W-1:0]     id_PC_sel,
  input  logic                   id_ALUSrcA,
  input  logic                   id_ALUSrcB,
  input  logic                   id_MemRead,
  input  logic                   id_RegWrite,
  input  logic                   id_MemWrite,
  input  logic                   id_Jump,
  input  logic [ALUCTRL_W-1:0]   id_ALUCtrl,
  input  logic [DW-1:0]          id_pc4,
  input  logic [DW-1:0]          id_rd1,
  input  logic [DW-1:0]          id_rd2,
  input  logic [DW-1:0]          id_imm,
  input  logic [RW-1:0]          id_rs,
  input  logic [RW-1:0]          id_rt,
  input  logic [RW-1:0]          id_rd,
  input  logic [RW-1:0]          id_shamt,
  input  logic                   flush,
  input  logic                   hold,
  output logic                   ex_valid,
  output logic [REGDST_W-1:0]    ex_RegDst,
  output logic [DATATOREG_W-1:0] ex_DatatoReg,
  output logic [PCSEL_W-1:0]     ex_PC_sel,
  output logic                   ex_ALUSrcA,
  output logic                   ex_ALUSrcB,
  output logic                   ex_MemRead,
  output logic                   ex_RegWrite,
  output logic                   ex_MemWrite,
  output logic                   ex_Jump,
  output logic [ALUCTRL_W-1:0]   ex_ALUCtrl,
  output logic [DW-1:0]          ex_pc4,
  output logic [DW-1:0]          ex_rd1,
  output logic [DW-1:0]          ex_rd2,
  output logic [DW-1:0]          ex_imm,
  output logic [RW-1:0]          ex_rs,
  output logic [RW-1:0]          ex_rt,
  output logic [RW-1:0]          ex_rd,
  output logic [RW-1:0]          ex_shamt,
  output logic                   stall_req
);

  ctrl_t         id_ctrl;
  ctrl_t         ctrl_q;
  logic          valid_q;
  logic [DW-1:0] pc4_q, rd1_q, rd2_q, imm_q;
  logic [RW-1:0] rs_q, rt_q, rd_q, shamt_q;

  logic keep;
  logic take_bubble;

  always_comb begin
    id_ctrl            = CTRL_BUBBLE;
    id_ctrl.reg_dst    = id_RegDst;
    id_ctrl.datato_reg = id_DatatoReg;
    id_ctrl.pc_sel     = id_PC_sel;
    id_ctrl.alu_src_a  = id_ALUSrcA;
    id_ctrl.alu_src_b  = id_ALUSrcB;
    id_ctrl.mem_read   = id_MemRead;
    id_ctrl.reg_write  = id_RegWrite;
    id_ctrl.mem_write  = id_MemWrite;
    id_ctrl.jump       = id_Jump;
    id_ctrl.alu_ctrl   = id_ALUCtrl;
  end

`ifdef LOAD_USE_DETECT_EN
  logic hazard;

  load_use_det #(.RW(RW)) u_load_use_det (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rt       (rt_q),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .flush       (flush),
    .hazard      (hazard)
  );

  // The register is frozen under hold, so a stall request would be redundant.
  assign stall_req = hazard && !hold;
`else
  assign stall_req = 1'b0;
`endif

  // flush beats hold; stall_req is already masked by hold and flush.
  assign keep        = hold && !flush;
  assign take_bubble = flush || stall_req || !id_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_BUBBLE;
      pc4_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      shamt_q <= '0;
    end else if (!keep) begin
      if (take_bubble) begin
        valid_q <= 1'b0;
        ctrl_q  <= CTRL_BUBBLE;
        pc4_q   <= '0;
        rd1_q   <= '0;
        rd2_q   <= '0;
        imm_q   <= '0;
        rs_q    <= '0;
        rt_q    <= '0;
        rd_q    <= '0;
        shamt_q <= '0;
      end else begin
        valid_q <= 1'b1;
        ctrl_q  <= id_ctrl;
        pc4_q   <= id_pc4;
        rd1_q   <= id_rd1;
        rd2_q   <= id_rd2;
        imm_q   <= id_imm;
        rs_q    <= id_rs;
        rt_q    <= id_rt;
        rd_q    <= id_rd;
        shamt_q <= id_shamt;
      end
    end
  end

  assign ex_valid     = valid_q;
  assign ex_RegDst    = ctrl_q.reg_dst;
  assign ex_DatatoReg = ctrl_q.datato_reg;
  assign ex_PC_sel    = ctrl_q.pc_sel;
  assign ex_ALUSrcA   = ctrl_q.alu_src_a;
  assign ex_ALUSrcB   = ctrl_q.alu_src_b;
  assign ex_MemRead   = ctrl_q.mem_read;
  assign ex_RegWrite  = ctrl_q.reg_write;
  assign ex_MemWrite  = ctrl_q.mem_write;
  assign ex_Jump      = ctrl_q.jump;
  assign ex_ALUCtrl   = ctrl_q.alu_ctrl;
  assign ex_pc4       = pc4_q;
  assign ex_rd1       = rd1_q;
  assign ex_rd2       = rd2_q;
  assign ex_imm       = imm_q;
  assign ex_rs        = rs_q;
  assign ex_rt        = rt_q;
  assign ex_rd        = rd_q;
  assign ex_shamt     = shamt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed self-checking bench for id_ex_pipe.
// Expected EX words are built from the bench's own copy of the ID fields
// captured at the moment they are presented; a bubble is all zeros.
// Load-use expectations follow LOAD_USE_DETECT_EN.
module tb_id_ex_pipe;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
`ifdef LOAD_USE_DETECT_EN
  localparam bit LUD = 1'b1;
`else
  localparam bit LUD = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic [1:0]    id_RegDst, id_DatatoReg, id_PC_sel;
  logic          id_ALUSrcA, id_ALUSrcB, id_MemRead, id_RegWrite, id_MemWrite, id_Jump;
  logic [4:0]    id_ALUCtrl;
  logic [DW-1:0] id_pc4, id_rd1, id_rd2, id_imm;
  logic [RW-1:0] id_rs, id_rt, id_rd, id_shamt;
  logic          flush, hold;
  logic          ex_valid;
  logic [1:0]    ex_RegDst, ex_DatatoReg, ex_PC_sel;
  logic          ex_ALUSrcA, ex_ALUSrcB, ex_MemRead, ex_RegWrite, ex_MemWrite, ex_Jump;
  logic [4:0]    ex_ALUCtrl;
  logic [DW-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [RW-1:0] ex_rs, ex_rt, ex_rd, ex_shamt;
  logic          stall_req;

  int n_vec;
  int n_miss;
  logic [191:0] exp_q[$];
  logic [191:0] exp_w;
  logic [191:0] add_w;

  id_ex_pipe #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_RegDst(id_RegDst), .id_DatatoReg(id_DatatoReg), .id_PC_sel(id_PC_sel),
    .id_ALUSrcA(id_ALUSrcA), .id_ALUSrcB(id_ALUSrcB), .id_MemRead(id_MemRead),
    .id_RegWrite(id_RegWrite), .id_MemWrite(id_MemWrite), .id_Jump(id_Jump),
    .id_ALUCtrl(id_ALUCtrl), .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .flush(flush), .hold(hold), .ex_valid(ex_valid),
    .ex_RegDst(ex_RegDst), .ex_DatatoReg(ex_DatatoReg), .ex_PC_sel(ex_PC_sel),
    .ex_ALUSrcA(ex_ALUSrcA), .ex_ALUSrcB(ex_ALUSrcB), .ex_MemRead(ex_MemRead),
    .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite), .ex_Jump(ex_Jump),
    .ex_ALUCtrl(ex_ALUCtrl), .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
    .stall_req(stall_req)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side image of what EX should hold after loading the current ID fields.
  function automatic logic [191:0] id_word();
    return {26'b0, 1'b1, id_RegDst, id_DatatoReg, id_PC_sel, id_ALUSrcA, id_ALUSrcB,
            id_MemRead, id_RegWrite, id_MemWrite, id_Jump, id_ALUCtrl,
            id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_shamt};
  endfunction

  function automatic logic [191:0] ex_word();
    return {26'b0, ex_valid, ex_RegDst, ex_DatatoReg, ex_PC_sel, ex_ALUSrcA, ex_ALUSrcB,
            ex_MemRead, ex_RegWrite, ex_MemWrite, ex_Jump, ex_ALUCtrl,
            ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_shamt};
  endfunction

  task automatic check_vec(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ex(input string tag);
    check_vec(tag, ex_word(), exp_q.pop_front());
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic clear_id();
    id_valid = 1'b0; id_RegDst = '0; id_DatatoReg = '0; id_PC_sel = '0;
    id_ALUSrcA = 1'b0; id_ALUSrcB = 1'b0; id_MemRead = 1'b0; id_RegWrite = 1'b0;
    id_MemWrite = 1'b0; id_Jump = 1'b0; id_ALUCtrl = '0;
    id_pc4 = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_shamt = '0;
  endtask

  task automatic rand_id();
    id_valid = 1'b1;
    id_RegDst = 2'($urandom); id_DatatoReg = 2'($urandom); id_PC_sel = 2'($urandom);
    id_ALUSrcA = 1'($urandom); id_ALUSrcB = 1'($urandom); id_MemRead = 1'($urandom);
    id_RegWrite = 1'($urandom); id_MemWrite = 1'($urandom); id_Jump = 1'($urandom);
    id_ALUCtrl = 5'($urandom);
    id_pc4 = $urandom; id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
    id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
    id_shamt = 5'($urandom);
  endtask

  task automatic drive_addi(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
    clear_id();
    id_valid = 1'b1; id_ALUCtrl = ALU_ADD; id_ALUSrcB = 1'b1; id_RegWrite = 1'b1;
    id_rs = rs; id_rt = rt; id_imm = imm;
    id_pc4 = 32'h0000_0104; id_rd1 = 32'h0000_0011; id_rd2 = 32'h0000_0022;
  endtask

  task automatic drive_lw(input logic [4:0] rs, input logic [4:0] rt);
    clear_id();
    id_valid = 1'b1; id_ALUCtrl = ALU_ADD; id_ALUSrcB = 1'b1; id_MemRead = 1'b1;
    id_RegWrite = 1'b1; id_DatatoReg = 2'b01; id_rs = rs; id_rt = rt;
    id_imm = 32'h0000_0004; id_pc4 = 32'h0000_0108; id_rd1 = 32'h0000_1000;
  endtask

  task automatic drive_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    clear_id();
    id_valid = 1'b1; id_ALUCtrl = ALU_ADD; id_RegDst = 2'b01; id_RegWrite = 1'b1;
    id_rs = rs; id_rt = rt; id_rd = rd; id_pc4 = 32'h0000_010c;
    id_rd1 = 32'hdead_beef; id_rd2 = 32'h1234_5678; id_shamt = 5'd3;
  endtask

  task automatic drive_sw(input logic [4:0] rs, input logic [4:0] rt);
    clear_id();
    id_valid = 1'b1; id_ALUCtrl = ALU_ADD; id_ALUSrcB = 1'b1; id_MemWrite = 1'b1;
    id_rs = rs; id_rt = rt; id_imm = 32'hffff_fff8; id_pc4 = 32'h0000_0110;
    id_rd1 = 32'h0000_2000; id_rd2 = 32'h0000_00aa;
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    flush = 1'b0; hold = 1'b0; rst_n = 1'b0;
    #1;
    // Reset with random ID traffic.
    for (int i = 0; i < 2; i++) begin
      rand_id();
      step();
      exp_q.push_back('0);
      check_ex("reset_ex");
      check_vec("reset_stall", 192'(stall_req), '0);
    end
    rst_n = 1'b1;

    // Pass-through: addi.
    drive_addi(5'd8, 5'd9, 32'h0000_0005);
    #1 check_vec("addi_stall", 192'(stall_req), '0);
    exp_q.push_back(id_word());
    step();
    check_ex("addi_pass");

    // Load-use: lw $9, then add using $9.
    drive_lw(5'd8, 5'd9);
    #1 check_vec("lw_no_stall", 192'(stall_req), '0);
    exp_q.push_back(id_word());
    step();
    check_ex("lw_pass");
    drive_add(5'd9, 5'd10, 5'd11);
    add_w = id_word();
    #1 check_vec("lu_stall", 192'(stall_req), 192'(LUD));
    exp_q.push_back(LUD ? 192'b0 : add_w);
    step();
    check_ex("lu_bubble");
    check_vec("lu_stall_clear", 192'(stall_req), '0);
    exp_q.push_back(add_w);
    step();
    check_ex("lu_add_enters");

    // Load to $0 never stalls.
    drive_lw(5'd8, 5'd0);
    exp_q.push_back(id_word());
    step();
    check_ex("lw0_pass");
    drive_add(5'd0, 5'd0, 5'd12);
    #1 check_vec("lw0_stall", 192'(stall_req), '0);
    exp_q.push_back(id_word());
    step();
    check_ex("lw0_no_bubble");

    // flush overrides hold.
    drive_sw(5'd8, 5'd9);
    exp_q.push_back(id_word());
    step();
    check_ex("sw_pass");
    hold = 1'b1; flush = 1'b1;
    #1 check_vec("fh_stall", 192'(stall_req), '0);
    exp_q.push_back('0);
    step();
    check_ex("flush_over_hold");
    hold = 1'b0; flush = 1'b0;

    // flush while a hazard is present: bubble, stall_req masked.
    drive_lw(5'd8, 5'd9);
    exp_q.push_back(id_word());
    step();
    check_ex("lw2_pass");
    drive_add(5'd9, 5'd9, 5'd13);
    flush = 1'b1;
    #1 check_vec("flush_masks_stall", 192'(stall_req), '0);
    exp_q.push_back('0);
    step();
    check_ex("flush_bubble");
    flush = 1'b0;

    // Hold for 3 cycles with a load in EX and changing hazardous ID fields.
    drive_lw(5'd4, 5'd7);
    exp_w = id_word();
    exp_q.push_back(exp_w);
    step();
    check_ex("lw3_pass");
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      id_rs = 5'd7;
      #1 check_vec("hold_stall", 192'(stall_req), '0);
      exp_q.push_back(exp_w);
      step();
      check_ex("hold_frozen");
    end
    hold = 1'b0;
    drive_add(5'd7, 5'd2, 5'd3);
    id_ALUCtrl = ALU_SUB;
    add_w = id_word();
    #1 check_vec("post_hold_stall", 192'(stall_req), 192'(LUD));
    exp_q.push_back(LUD ? 192'b0 : add_w);
    step();
    check_ex("post_hold_ex");

    // Reset asserted mid-hold discards contents.
    drive_sw(5'd1, 5'd2);
    exp_q.push_back(id_word());
    step();
    check_ex("sw2_pass");
    hold = 1'b1; rst_n = 1'b0;
    exp_q.push_back('0);
    step();
    check_ex("reset_mid_hold");
    check_vec("reset_mid_hold_stall", 192'(stall_req), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

ID/EX pipeline register of the five-stage MIPS pipeline. It captures the decoded control word from the instruction decoder, together with the register-file operands, extended immediate and register specifiers, and presents them to the EX stage one cycle later. It inserts bubbles for flush and load-use hazards and holds its contents while a downstream stall is active. It also generates the load-use stall request that freezes PC and IF/ID.

## Interface
Parameters:
- `DW`, 32, datapath width.
- `RW`, 5, register-specifier width.

Ports (clock and reset first):
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `id_valid`  in  1  the ID slot holds a real instruction.
- `id_RegDst`  in  2  decoder control field.
- `id_DatatoReg`  in  2  decoder control field.
- `id_PC_sel`  in  2  decoder control field.
- `id_ALUSrcA`, `id_ALUSrcB`, `id_MemRead`, `id_RegWrite`, `id_MemWrite`, `id_Jump`  in  1 each  decoder control bits.
- `id_ALUCtrl`  in  5  ALU operation code.
- `id_pc4`, `id_rd1`, `id_rd2`, `id_imm`  in  DW each  PC+4, rs data, rt data, extended immediate.
- `id_rs`, `id_rt`, `id_rd`, `id_shamt`  in  RW each  instruction fields.
- `flush`  in  1  branch/jump resolved taken; discard the ID instruction.
- `hold`  in  1  downstream (EX/MEM) stall; keep the current contents.
- `ex_*`  out  same widths  registered copies of every `id_*` field above, plus `ex_valid`.
- `stall_req`  out  1  load-use hazard; PC and IF/ID must hold this cycle.

## Operation
- A **bubble** is defined as `ex_valid`=0, all control outputs 0 (RegWrite, MemWrite, MemRead, Jump = 0; PC_sel, RegDst, DatatoReg = 2'b00; ALUCtrl = 5'b00000), and all data and specifier outputs 0.
- Next-state priority, highest first:
  1. `!rst_n`: load a bubble.
  2. `flush`: load a bubble. `flush` overrides `hold`.
  3. `hold`: keep every register unchanged.
  4. `stall_req`: load a bubble. The ID instruction is retained upstream and re-presented next cycle.
  5. `id_valid`=0: load a bubble.
  6. Otherwise: load every `id_*` field and set `ex_valid`=1.
- Load-use hazard: `stall_req` = `ex_valid` & `ex_MemRead` & (`ex_rt`≠0) & `id_valid` & (`ex_rt`==`id_rs` | `ex_rt`==`id_rt`) & !`flush`.
  - The rt comparison is conservative: it applies regardless of instruction type.
- `stall_req` is forced 0 while `hold` is asserted. The register is frozen in that case, so upstream must stall on `hold` anyway.
- No arithmetic is performed; fields pass through bit-exact.

## Timing
- Latency is 1 cycle: `id_*` sampled at edge N appear on `ex_*` after edge N.
- `stall_req` is combinational from the `ex_*` registers and the `id_*` inputs, and is valid within the same cycle.
- A load-use stall lasts exactly 1 cycle: the inserted bubble has `ex_MemRead`=0, so the hazard clears on the following cycle.
- Reset value of every output is the bubble. `stall_req` is therefore 0 during and after reset.
- Reset asserted mid-stall or mid-hold discards the contents on the next edge; there is no residual state.
- `flush` together with `stall_req` produces a bubble, and `stall_req` reads 0 because of the `!flush` term.

## Configuration
- `LOAD_USE_DETECT_EN`, defined: the hazard comparator is compiled in and `stall_req` behaves as above.
- Not defined: `stall_req` is tied to 0 and priority level 4 is removed. An external hazard unit must then drive `hold` upstream and `flush` here to insert bubbles.

## Structure
- Shared package holds:
  - the control-word field widths: RegDst, DatatoReg, PC_sel = 2 bits; ALUCtrl = 5 bits;
  - the bubble constant;
  - a packed control-word typedef shared with the decoder and the EX/MEM register.
- Sub-module `load_use_det` is purely combinational and contains the hazard equation. It is instantiated only under `LOAD_USE_DETECT_EN`.

## Test plan
- Reset: `rst_n`=0 for 2 cycles with random `id_*` -> all `ex_*`=0, `ex_valid`=0, `stall_req`=0.
- Pass-through: addi fields (ALUCtrl=ADD, ALUSrcB=1, rs=8, rt=9, imm=0x00000005, `id_valid`=1) -> identical values on `ex_*` one cycle later with `ex_valid`=1.
- Load-use: lw writing rt=9, then add with rs=9 -> `stall_req`=1 for exactly one cycle, a bubble in EX, then the add enters EX.
- Load-use with rt=0: lw to `$0`, then add using rs=0 -> `stall_req` stays 0 and there is no bubble.
- Flush over hold: `hold`=1 and `flush`=1 in the same cycle with a valid sw loaded -> next cycle MemWrite=0 and `ex_valid`=0.
- Hold: `hold`=1 for 3 cycles while `id_*` changes -> `ex_*` frozen at the pre-hold values, and `stall_req`=0 throughout.
